// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and the oversampling ratio
// common to the transmitter and receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted request as start bit, DBIT data bits
// LSB first, optional parity and SB_TICK s_ticks of stop, paced by a shared 16x s_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int             SW      = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0]  OS_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0]  SB_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST  = 3'(DBIT - 1);
    localparam logic [7:0]     D_MASK  = 8'((16'd1 << DBIT) - 16'd1);

    state_e         state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [2:0]     n_q, n_d;
    logic [7:0]     b_q, b_d;
    logic [7:0]     data_q, data_d;
    logic           tx_q, tx_d;
    logic           par_bit;

    // Parity comes from the byte captured at accept; b_q has been shifted away by then.
    assign par_bit = (^(data_q & D_MASK)) ^ (PARITY == PAR_ODD);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        data_d       = data_q;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = din;
                    data_d  = din;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SB_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level follows the state being entered, so tx_q lines up with state_q.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PAR:     tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the datapath registers
        // are reset too so a fresh frame never depends on leftovers.
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;

endmodule
